// File: rtl/top_pkg.sv
// rtl/top_pkg.sv - shared state types and default sizing for the UART image RAM block
package top_pkg;

  // One-hot encoding so the state register drives the status LEDs directly
  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_LOAD = 4'b0010,
    ST_DUMP = 4'b0100,
    ST_PROC = 4'b1000
  } state_t;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;

  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int DEF_MEM_DEPTH    = 256;

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, mid-bit sampling, drops false starts and framing errors
module uart_rx
  import top_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_data
);

  localparam int            CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  uart_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= U_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else begin
      o_valid <= 1'b0;
      case (r_state)
        U_IDLE: begin
          r_cnt <= '0;
          if (!i_rx) r_state <= U_START;
        end
        U_START: begin
          if (r_cnt == HALF) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= i_rx ? U_IDLE : U_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        U_DATA: begin
          if (r_cnt == LAST) begin
            r_cnt   <= '0;
            r_shift <= {i_rx, r_shift[7:1]};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_state <= U_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        U_STOP: begin
          if (r_cnt == LAST) begin
            r_state <= U_IDLE;
            if (i_rx) begin
              o_valid <= 1'b1;
              o_data  <= r_shift;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= U_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter; a start in the last stop cycle chains frames back-to-back
module uart_tx
  import top_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [7:0] i_data,
  input  logic       i_abort,
  output logic       o_tx,
  output logic       o_ready,
  output logic       o_done
);

  localparam int            CW   = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          w_bit_end;

  assign w_bit_end = (r_cnt == LAST);
  assign o_ready   = (r_state == U_IDLE) || (r_state == U_STOP && w_bit_end);
  assign o_done    = (r_state == U_STOP) && w_bit_end && !i_start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= U_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      o_tx    <= 1'b1;
    end else if (i_abort) begin
      r_state <= U_IDLE;
      r_cnt   <= '0;
      o_tx    <= 1'b1;
    end else if (o_ready && i_start) begin
      r_state <= U_START;
      r_cnt   <= '0;
      r_shift <= i_data;
      o_tx    <= 1'b0;
    end else begin
      case (r_state)
        U_IDLE: o_tx <= 1'b1;
        U_START: begin
          if (w_bit_end) begin
            r_state <= U_DATA;
            r_cnt   <= '0;
            r_bit   <= '0;
            o_tx    <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        U_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            r_bit <= r_bit + 1'b1;
            if (r_bit == 3'd7) begin
              r_state <= U_STOP;
              o_tx    <= 1'b1;
            end else begin
              o_tx    <= r_shift[1];
              r_shift <= r_shift >> 1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        U_STOP: begin
          if (w_bit_end) begin
            r_state <= U_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= U_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/top.sv
// rtl/top.sv - command FSM, address counter, pixel RAM and inverter between a PC UART link and RAM
module top
  import top_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int MEM_DEPTH    = DEF_MEM_DEPTH
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PC_RAM_ACT,
  input  logic       RAM_PC_ACT,
  input  logic       PROCESS_ACT,
  input  logic       IDLE_ACT,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] led
);

  localparam int                ADDR_W    = $clog2(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(MEM_DEPTH - 1);

  logic [4:0]        r_sync1, r_sync2;
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic              r_done, r_phase, r_dvalid, r_last;
  logic [7:0]        r_mem [MEM_DEPTH];
  logic [7:0]        r_rdata;
  logic              w_idle_cmd, w_load_cmd, w_dump_cmd, w_proc_cmd, w_rx_s;
  logic              w_rx_valid, w_tx_ready, w_tx_done, w_tx_go, w_we;
  logic [7:0]        w_rx_data, w_wdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 5'b00001;
      r_sync2 <= 5'b00001;
    end else begin
      r_sync1 <= {IDLE_ACT, PC_RAM_ACT, RAM_PC_ACT, PROCESS_ACT, rx};
      r_sync2 <= r_sync1;
    end
  end

  assign {w_idle_cmd, w_load_cmd, w_dump_cmd, w_proc_cmd, w_rx_s} = r_sync2;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk(clk), .rst_n(reset), .i_rx(w_rx_s), .o_valid(w_rx_valid), .o_data(w_rx_data)
  );

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk(clk), .rst_n(reset), .i_start(w_tx_go), .i_data(r_rdata), .i_abort(w_idle_cmd),
    .o_tx(tx), .o_ready(w_tx_ready), .o_done(w_tx_done)
  );

  // r_dvalid marks r_rdata as the read of the current r_addr (one cycle after any address move)
  assign w_tx_go = (r_state == ST_DUMP) && r_dvalid && !r_last && w_tx_ready && !w_idle_cmd;
  assign w_we    = !w_idle_cmd &&
                   (((r_state == ST_LOAD) && w_rx_valid) || ((r_state == ST_PROC) && r_phase));
  assign w_wdata = (r_state == ST_PROC) ? ~r_rdata : w_rx_data;

  always_ff @(posedge clk) begin
    if (w_we) r_mem[r_addr] <= w_wdata;
    r_rdata <= r_mem[r_addr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_done   <= 1'b0;
      r_phase  <= 1'b0;
      r_dvalid <= 1'b0;
      r_last   <= 1'b0;
    end else if (w_idle_cmd) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_addr   <= '0;
          r_phase  <= 1'b0;
          r_dvalid <= 1'b0;
          r_last   <= 1'b0;
          if (w_load_cmd) begin
            r_state <= ST_LOAD;
            r_done  <= 1'b0;
          end else if (w_dump_cmd) begin
            r_state <= ST_DUMP;
            r_done  <= 1'b0;
          end else if (w_proc_cmd) begin
            r_state <= ST_PROC;
            r_done  <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (w_rx_valid) begin
            if (r_addr == ADDR_LAST) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        ST_DUMP: begin
          if (w_tx_go) begin
            r_dvalid <= 1'b0;
            if (r_addr == ADDR_LAST) r_last <= 1'b1;
            else                     r_addr <= r_addr + 1'b1;
          end else begin
            r_dvalid <= 1'b1;
          end
          if (r_last && w_tx_done) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        ST_PROC: begin
          r_phase <= !r_phase;
          if (r_phase) begin
            if (r_addr == ADDR_LAST) begin
              r_state <= ST_IDLE;
              r_done  <= 1'b1;
            end else begin
              r_addr <= r_addr + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign led = {3'b000, r_done, r_state};

endmodule

// File: tb/tb_top.sv
// tb/tb_top.sv - self-checking bench for top: load, process, dump, abort, priority, framing error
module tb_top;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       pc_ram, ram_pc, proc_act, idle_act, rx;
  logic       tx;
  logic [7:0] led;
  logic [7:0] model_ram [DEPTH];
  int         n_checks = 0;
  int         n_fail   = 0;

  top #(.CLKS_PER_BIT(CPB), .MEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .PC_RAM_ACT(pc_ram), .RAM_PC_ACT(ram_pc),
    .PROCESS_ACT(proc_act), .IDLE_ACT(idle_act), .rx(rx), .tx(tx), .led(led)
  );

  always #5 clk = ~clk;

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sel = {PC_RAM_ACT, RAM_PC_ACT, PROCESS_ACT}, held across one rising edge
  task automatic pulse_cmd(input logic [2:0] sel);
    @(negedge clk);
    {pc_ram, ram_pc, proc_act} = sel;
    @(negedge clk);
    {pc_ram, ram_pc, proc_act} = 3'b000;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] frame;
    frame = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = frame[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; rx = 1'b0;
    pc_ram = 1'b0; ram_pc = 1'b0; proc_act = 1'b0; idle_act = 1'b0;
    #100;
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
    n_checks++;
    if (led !== 8'h01) begin n_fail++; $display("FAIL reset_led: got %h want 01", led); end
    @(negedge clk);
    reset = 1'b1; rx = 1'b1;
    wait_cycles(10);
    n_checks++;
    if (led !== 8'h01 || tx !== 1'b1) begin
      n_fail++; $display("FAIL post_reset: led %h tx %b want 01/1", led, tx);
    end
  endtask

  task automatic test_load(input logic [31:0] bytes);
    pulse_cmd(3'b100);
    wait_cycles(3);
    n_checks++;
    if (led !== 8'h02) begin n_fail++; $display("FAIL load_enter: led %h want 02", led); end
    pulse_cmd(3'b001);
    wait_cycles(3);
    n_checks++;
    if (led !== 8'h02) begin n_fail++; $display("FAIL load_ignore_cmd: led %h want 02", led); end
    for (int i = 0; i < DEPTH; i++) begin
      model_ram[i] = bytes[8*i +: 8];
      send_byte(bytes[8*i +: 8], 1'b1);
      wait_cycles(4);
      n_checks++;
      if (led !== ((i < DEPTH - 1) ? 8'h02 : 8'h11)) begin
        n_fail++; $display("FAIL load_led byte %0d: led %h", i, led);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (dut.r_mem[i] !== model_ram[i]) begin
        n_fail++; $display("FAIL load_ram[%0d]: got %h want %h", i, dut.r_mem[i], model_ram[i]);
      end
    end
  endtask

  task automatic test_process();
    int t, n;
    pulse_cmd(3'b001);
    t = 0;
    while (led !== 8'h08 && t < 20) begin @(negedge clk); t++; end
    n = 0;
    while (led === 8'h08 && n < 100) begin @(negedge clk); n++; end
    n_checks++;
    if (n != 2 * DEPTH) begin n_fail++; $display("FAIL proc_cycles: got %0d want %0d", n, 2 * DEPTH); end
    n_checks++;
    if (led !== 8'h11) begin n_fail++; $display("FAIL proc_done: led %h want 11", led); end
    for (int i = 0; i < DEPTH; i++) begin
      model_ram[i] = 8'(8'd255 - model_ram[i]);
      n_checks++;
      if (dut.r_mem[i] !== model_ram[i]) begin
        n_fail++; $display("FAIL proc_ram[%0d]: got %h want %h", i, dut.r_mem[i], model_ram[i]);
      end
    end
  endtask

  task automatic test_dump();
    logic [39:0] exp_f, got_f;
    int t;
    pulse_cmd(3'b010);
    t = 0;
    while (tx !== 1'b0 && t < 30) begin @(negedge clk); t++; end
    n_checks++;
    if (tx !== 1'b0) begin n_fail++; $display("FAIL dump_start: tx %b want 0 within 30 cycles", tx); end
    for (int f = 0; f < DEPTH; f++) begin
      for (int j = 0; j < 40; j++) begin
        if (j < 4)        exp_f[j] = 1'b0;
        else if (j >= 36) exp_f[j] = 1'b1;
        else              exp_f[j] = model_ram[f][(j - 4) / 4];
        got_f[j] = tx;
        @(negedge clk);
      end
      n_checks++;
      if (got_f !== exp_f) begin
        n_fail++; $display("FAIL dump_frame %0d: got %h want %h", f, got_f, exp_f);
      end
    end
    n_checks++;
    if (led !== 8'h11 || tx !== 1'b1) begin
      n_fail++; $display("FAIL dump_done: led %h tx %b want 11/1", led, tx);
    end
  endtask

  task automatic test_abort();
    int t;
    logic saw_low;
    pulse_cmd(3'b010);
    t = 0;
    while (tx !== 1'b0 && t < 30) begin @(negedge clk); t++; end
    wait_cycles(10);
    idle_act = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (led !== 8'h01) begin n_fail++; $display("FAIL abort_led: led %h want 01", led); end
    n_checks++;
    if (tx !== 1'b1) begin n_fail++; $display("FAIL abort_tx: tx %b want 1", tx); end
    @(negedge clk);
    idle_act = 1'b0;
    saw_low = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (tx !== 1'b1) saw_low = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (saw_low !== 1'b0 || led !== 8'h01) begin
      n_fail++; $display("FAIL abort_quiet: tx_low %b led %h want 0/01", saw_low, led);
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (dut.r_mem[i] !== model_ram[i]) begin
        n_fail++; $display("FAIL abort_ram[%0d]: got %h want %h", i, dut.r_mem[i], model_ram[i]);
      end
    end
  endtask

  task automatic test_priority();
    @(negedge clk);
    {pc_ram, ram_pc, proc_act} = 3'b111;
    @(negedge clk);
    {pc_ram, ram_pc, proc_act} = 3'b000;
    wait_cycles(3);
    n_checks++;
    if (led !== 8'h02) begin n_fail++; $display("FAIL prio_load: led %h want 02", led); end
    idle_act = 1'b1;
    wait_cycles(4);
    n_checks++;
    if (led !== 8'h01) begin n_fail++; $display("FAIL prio_abort_load: led %h want 01", led); end
    pc_ram = 1'b1;
    wait_cycles(4);
    n_checks++;
    if (led !== 8'h01) begin n_fail++; $display("FAIL prio_idle_wins: led %h want 01", led); end
    pc_ram = 1'b0; idle_act = 1'b0;
    wait_cycles(4);
    n_checks++;
    if (led !== 8'h01) begin n_fail++; $display("FAIL prio_release: led %h want 01", led); end
  endtask

  task automatic test_framing_error();
    logic [31:0] w;
    w = $urandom();
    pulse_cmd(3'b100);
    wait_cycles(3);
    send_byte(w[7:0], 1'b1);
    wait_cycles(4);
    send_byte(8'h55, 1'b0);
    wait_cycles(3 * CPB);
    send_byte(w[15:8], 1'b1);
    wait_cycles(4);
    n_checks++;
    if (dut.r_mem[1] !== w[15:8]) begin
      n_fail++; $display("FAIL ferr_same_addr: ram[1] %h want %h", dut.r_mem[1], w[15:8]);
    end
    send_byte(w[23:16], 1'b1);
    wait_cycles(4);
    n_checks++;
    if (led !== 8'h02) begin n_fail++; $display("FAIL ferr_not_counted: led %h want 02", led); end
    send_byte(w[31:24], 1'b1);
    wait_cycles(4);
    n_checks++;
    if (led !== 8'h11) begin n_fail++; $display("FAIL ferr_done: led %h want 11", led); end
    for (int i = 0; i < DEPTH; i++) begin
      model_ram[i] = w[8*i +: 8];
      n_checks++;
      if (dut.r_mem[i] !== model_ram[i]) begin
        n_fail++; $display("FAIL ferr_ram[%0d]: got %h want %h", i, dut.r_mem[i], model_ram[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load(32'hFF_A5_12_00);
    test_process();
    test_dump();
    test_abort();
    test_priority();
    test_framing_error();
    for (int k = 0; k < 2; k++) begin
      test_load($urandom());
      test_process();
      test_dump();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
